// File: rtl/adc_reader_pkg.sv
// Shared definitions for the AD7673 serial reader: FSM state encoding,
// ADC word width and default timing constants derived from the 150MHz clock.
// Optional build macro used by the reader: ADC_READER_TWOS_COMP_EN.
package adc_reader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    SHIFT   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int CLK_MHZ = 150;

  // Rounds a duration up to whole clk cycles so minimum widths are never violated.
  function automatic int ns_to_cycles(input int ns);
    return (ns * CLK_MHZ + 999) / 1000;
  endfunction

  localparam int DEF_DATA_BITS        = 18;
  localparam int DEF_INDEX_BITS       = 6;
  localparam int DEF_CNVST_LOW_CYCLES = ns_to_cycles(20);    // 3 cycles, ADC needs >=15ns
  localparam int DEF_SCLK_HALF        = 4;                   // ~18.75MHz SCLK
  localparam int DEF_BUSY_TIMEOUT     = ns_to_cycles(2000);  // 300 cycles

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
// Latency: 2 clk cycles. No backpressure.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_serial_reader.sv
// Per-ADC conversion responder: start pulse -> CNVST_N, wait BUSY, read 18 bits, present sample.
// Latency: CNVST_LOW + ADC busy time + DATA_BITS*2*SCLK_HALF + a few sync cycles.
// No backpressure: starts arriving while busy are dropped and flagged as overrun.
// Build macro ADC_READER_TWOS_COMP_EN: present data in two's complement instead of offset binary.
module adc_serial_reader
  import adc_reader_pkg::*;
#(
  parameter int CNVST_LOW_CYCLES = DEF_CNVST_LOW_CYCLES,
  parameter int SCLK_HALF        = DEF_SCLK_HALF,
  parameter int BUSY_TIMEOUT     = DEF_BUSY_TIMEOUT,
  parameter int DATA_BITS        = DEF_DATA_BITS,
  parameter int INDEX_BITS       = DEF_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  start,
  output logic                  CNVST_N,
  input  logic                  BUSY,
  output logic                  CS_N,
  output logic                  SCLK,
  input  logic                  SDOUT,
  output logic                  data_valid,
  output logic [DATA_BITS-1:0]  data,
  output logic [INDEX_BITS-1:0] sample_index,
  output logic                  overrun,
  output logic                  timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int PW = $clog2(2 * SCLK_HALF);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] CNV_LAST = TW'(CNVST_LOW_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * SCLK_HALF - 1);
  localparam logic [PW-1:0] PH_HIGH  = PW'(SCLK_HALF);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  state_t state, state_next;

  logic                  busy_s;
  logic [TW-1:0]         tcnt, tcnt_next;      // cycles since CNVST_N fell
  logic [PW-1:0]         pc, pc_next;          // phase within one SCLK period
  logic [BW-1:0]         bcnt, bcnt_next;      // bit number being clocked
  logic [DATA_BITS-2:0]  shreg, shreg_next;    // all bits but the last one
  logic [INDEX_BITS-1:0] idx_cnt, idx_next;
  logic [DATA_BITS-1:0]  word;
  logic                  cnvst_next, cs_next, sclk_next, dv_next;
  logic [DATA_BITS-1:0]  data_next;
  logic [INDEX_BITS-1:0] sidx_next;
  logic                  ovr_next, tmo_next;

  sync_2ff u_busy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (BUSY),
    .q     (busy_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus next value of every counter and registered ADC/host output.
  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    pc_next    = pc;
    bcnt_next  = bcnt;
    shreg_next = shreg;
    idx_next   = idx_cnt;
    cnvst_next = CNVST_N;
    cs_next    = CS_N;
    dv_next    = 1'b0;
    data_next  = data;
    sidx_next  = sample_index;
    ovr_next   = overrun;
    tmo_next   = timeout_err;

    // The completed word is the stored bits plus the bit on SDOUT right now.
    word = {shreg, SDOUT};
`ifdef ADC_READER_TWOS_COMP_EN
    word[DATA_BITS-1] = ~word[DATA_BITS-1];
`endif

    if (frame_start) begin
      idx_next = '0;
      ovr_next = 1'b0;
      tmo_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          cnvst_next = 1'b0;
          tcnt_next  = '0;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        tcnt_next = tcnt + 1'b1;
        if (tcnt == CNV_LAST) begin
          cnvst_next = 1'b1;
          state_next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        tcnt_next = tcnt + 1'b1;
        if (busy_s) begin
          state_next = WAIT_LO;
        end else if (tcnt == TMO_LAST) begin
          tmo_next   = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_LO: begin
        if (!busy_s) begin
          cs_next    = 1'b0;
          pc_next    = '0;
          bcnt_next  = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (pc == PH_LAST) begin
          pc_next = '0;
          if (bcnt == BIT_LAST) begin
            cs_next    = 1'b1;
            dv_next    = 1'b1;
            data_next  = word;
            // A frame_start landing on this cycle already belongs to this sample.
            sidx_next  = frame_start ? '0 : idx_cnt;
            state_next = DONE;
          end else begin
            shreg_next = {shreg[DATA_BITS-3:0], SDOUT};
            bcnt_next  = bcnt + 1'b1;
          end
        end else begin
          pc_next = pc + 1'b1;
        end
      end
      DONE: begin
        if (!frame_start) idx_next = idx_cnt + 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (start && (state != IDLE)) ovr_next = 1'b1;

    // SCLK is registered so the ADC never sees a decode glitch.
    sclk_next = (state_next == SHIFT) && (pc_next >= PH_HIGH);
  end

  // Counters, shift register and all outputs, registered from the next-value logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt         <= '0;
      pc           <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      idx_cnt      <= '0;
      CNVST_N      <= 1'b1;
      CS_N         <= 1'b1;
      SCLK         <= 1'b0;
      data_valid   <= 1'b0;
      data         <= '0;
      sample_index <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      tcnt         <= tcnt_next;
      pc           <= pc_next;
      bcnt         <= bcnt_next;
      shreg        <= shreg_next;
      idx_cnt      <= idx_next;
      CNVST_N      <= cnvst_next;
      CS_N         <= cs_next;
      SCLK         <= sclk_next;
      data_valid   <= dv_next;
      data         <= data_next;
      sample_index <= sidx_next;
      overrun      <= ovr_next;
      timeout_err  <= tmo_next;
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: behavioural AD7673 model (BUSY after CNVST_N fall,
// SDOUT shifted MSB first on SCLK falling edges) and a sample/index reference model.
module tb_adc_serial_reader;

  localparam int DB = 18;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic reset, frame_start, start;
  logic BUSY = 1'b0;
  logic SDOUT = 1'b0;
  logic CNVST_N, CS_N, SCLK, data_valid, overrun, timeout_err;
  logic [DB-1:0] data;
  logic [5:0] sample_index;

  adc_serial_reader dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .start        (start),
    .CNVST_N      (CNVST_N),
    .BUSY         (BUSY),
    .CS_N         (CS_N),
    .SCLK         (SCLK),
    .SDOUT        (SDOUT),
    .data_valid   (data_valid),
    .data         (data),
    .sample_index (sample_index),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #3 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int model_idx = 0;

  // ADC model controls, written only by the test tasks.
  logic [DB-1:0] adc_word = '0;
  bit busy_en = 1'b0;
  int busy_delay = 10;
  int busy_len = 100;

  // Observations, written only by the monitor.
  int fall_cyc = -100000;
  int cnv_falls = 0, low_run = 0, last_low = 0;
  int sclk_rises = 0, last_rise = -1, period_err = 0, hi_run = 0, hi_err = 0;
  int cs_falls = 0, sd_ptr = DB - 1, dv_count = 0;
  logic [DB-1:0] dv_data [0:255];
  logic [5:0] dv_idx [0:255];
  bit prev_cnvst = 1'b1, prev_sclk = 1'b0, prev_cs = 1'b1;

  // ADC behaviour and line monitor, evaluated once per cycle away from the active edge.
  always @(negedge clk) begin
    if (CNVST_N === 1'b0) begin
      if (prev_cnvst) begin
        fall_cyc  = cyc;
        cnv_falls = cnv_falls + 1;
      end
      low_run = low_run + 1;
    end else begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
    end
    BUSY = busy_en && (cyc >= fall_cyc + busy_delay) && (cyc < fall_cyc + busy_delay + busy_len);

    if (CS_N !== 1'b0) last_rise = -1;
    if (SCLK === 1'b1) begin
      if (!prev_sclk) begin
        sclk_rises = sclk_rises + 1;
        if (last_rise >= 0 && (cyc - last_rise) != 2 * H) period_err = period_err + 1;
        last_rise = cyc;
      end
      hi_run = hi_run + 1;
    end else begin
      if (hi_run != 0 && hi_run != H) hi_err = hi_err + 1;
      hi_run = 0;
    end
    if (prev_cs && CS_N === 1'b0) cs_falls = cs_falls + 1;

    if (CS_N !== 1'b0) sd_ptr = DB - 1;
    else if (prev_sclk && SCLK === 1'b0 && sd_ptr > 0) sd_ptr = sd_ptr - 1;
    SDOUT = adc_word[sd_ptr];

    if (data_valid === 1'b1) begin
      if (dv_count < 256) begin
        dv_data[dv_count] = data;
        dv_idx[dv_count]  = sample_index;
      end
      dv_count = dv_count + 1;
    end
    prev_cnvst = (CNVST_N !== 1'b0);
    prev_sclk  = (SCLK === 1'b1);
    prev_cs    = (CS_N !== 1'b0);
  end

  function automatic logic [DB-1:0] exp_word(input logic [DB-1:0] w);
`ifdef ADC_READER_TWOS_COMP_EN
    return {~w[DB-1], w[DB-2:0]};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [DB-1:0] w, input int dly, input int len, input bit fs);
    adc_word = w;
    busy_delay = dly;
    busy_len = len;
    busy_en = 1'b1;
    start = 1'b1;
    frame_start = fs;
    tick();
    start = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_dv(input int n0, output bit got);
    for (int i = 0; i < 3000; i++) begin
      if (dv_count != n0) break;
      tick();
    end
    got = (dv_count != n0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    frame_start = 1'b0;
    repeat (3) tick();
    total++;
    if ({CNVST_N, CS_N, SCLK, data_valid, overrun, timeout_err} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=110000", {CNVST_N, CS_N, SCLK, data_valid, overrun, timeout_err});
    end
    total++;
    if (data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
    total++;
    if (sample_index !== '0) begin bad++; $display("FAIL reset_index got=%0d exp=0", sample_index); end
    reset = 1'b1;
    model_idx = 0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int r0, p0, h0, f0, n0;
    bit got;
    r0 = sclk_rises; p0 = period_err; h0 = hi_err; f0 = cnv_falls; n0 = dv_count;
    pulse_start(18'h2A5C3, 10, 100, 1'b0);
    wait_dv(n0, got);
    total++;
    if (!got) begin bad++; $display("FAIL basic_valid got=none exp=pulse"); end
    total++;
    if (dv_data[n0] !== exp_word(18'h2A5C3)) begin
      bad++; $display("FAIL basic_data got=%h exp=%h", dv_data[n0], exp_word(18'h2A5C3));
    end
    total++;
    if (dv_idx[n0] !== 6'(model_idx)) begin
      bad++; $display("FAIL basic_index got=%0d exp=%0d", dv_idx[n0], model_idx);
    end
    model_idx = (model_idx + 1) % 64;
    repeat (20) tick();
    total++;
    if (dv_count - n0 != 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", dv_count - n0); end
    total++;
    if (last_low != 3) begin bad++; $display("FAIL basic_cnvst_width got=%0d exp=3", last_low); end
    total++;
    if (sclk_rises - r0 != DB) begin bad++; $display("FAIL basic_sclk_count got=%0d exp=%0d", sclk_rises - r0, DB); end
    total++;
    if (period_err - p0 != 0 || hi_err - h0 != 0) begin
      bad++; $display("FAIL basic_sclk_shape period_errs=%0d high_errs=%0d exp=0", period_err - p0, hi_err - h0);
    end
    total++;
    if (cnv_falls - f0 != 1) begin bad++; $display("FAIL basic_cnvst_falls got=%0d exp=1", cnv_falls - f0); end
  endtask

  task automatic test_timeout();
    int r0, c0, n0, f0, fc;
    r0 = sclk_rises; c0 = cs_falls; n0 = dv_count; f0 = cnv_falls;
    busy_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cnv_falls != f0) break;
      tick();
    end
    fc = fall_cyc;
    total++;
    if (cnv_falls == f0) begin
      bad++; $display("FAIL timeout_cnvst got=no_fall exp=fall");
    end else begin
      for (int i = 0; i < 400; i++) begin
        if (cyc >= fc + 299) break;
        tick();
      end
      total++;
      if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0 at_cycle=299", timeout_err); end
      tick();
      total++;
      if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b exp=1 at_cycle=300", timeout_err); end
    end
    repeat (30) tick();
    total++;
    if (sclk_rises != r0 || cs_falls != c0 || dv_count != n0) begin
      bad++; $display("FAIL timeout_quiet sclk=%0d cs=%0d dv=%0d exp=0,0,0", sclk_rises - r0, cs_falls - c0, dv_count - n0);
    end
  endtask

  task automatic test_overrun();
    int r0, c0, n0, f0;
    bit got;
    logic [DB-1:0] w;
    w = DB'($urandom);
    r0 = sclk_rises; c0 = cs_falls; n0 = dv_count; f0 = cnv_falls;
    pulse_start(w, $urandom_range(12, 2), $urandom_range(40, 6), 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (cs_falls != c0 && sclk_rises - r0 >= 3) break;
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_dv(n0, got);
    total++;
    if (!got || dv_data[n0] !== exp_word(w)) begin
      bad++; $display("FAIL overrun_data got=%h exp=%h", dv_data[n0], exp_word(w));
    end
    total++;
    if (dv_idx[n0] !== 6'(model_idx)) begin bad++; $display("FAIL overrun_index got=%0d exp=%0d", dv_idx[n0], model_idx); end
    model_idx = (model_idx + 1) % 64;
    repeat (300) tick();
    total++;
    if (dv_count - n0 != 1 || cnv_falls - f0 != 1) begin
      bad++; $display("FAIL overrun_single dv=%0d falls=%0d exp=1,1", dv_count - n0, cnv_falls - f0);
    end
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
  endtask

  task automatic test_frame_start_inflight();
    int c0, n0;
    bit got;
    logic [DB-1:0] w;
    w = DB'($urandom);
    c0 = cs_falls; n0 = dv_count;
    pulse_start(w, $urandom_range(12, 2), $urandom_range(40, 6), 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (cs_falls != c0) break;
      tick();
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_idx = 0;
    total++;
    if (overrun !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL fs_clear overrun=%b timeout_err=%b exp=0,0", overrun, timeout_err);
    end
    wait_dv(n0, got);
    total++;
    if (!got || dv_data[n0] !== exp_word(w) || dv_idx[n0] !== 6'(model_idx)) begin
      bad++; $display("FAIL fs_inflight data=%h idx=%0d exp=%h,%0d", dv_data[n0], dv_idx[n0], exp_word(w), model_idx);
    end
    model_idx = (model_idx + 1) % 64;
    n0 = dv_count;
    w = DB'($urandom);
    pulse_start(w, $urandom_range(12, 2), $urandom_range(40, 6), 1'b0);
    wait_dv(n0, got);
    total++;
    if (!got || dv_data[n0] !== exp_word(w) || dv_idx[n0] !== 6'(model_idx)) begin
      bad++; $display("FAIL fs_next data=%h idx=%0d exp=%h,%0d", dv_data[n0], dv_idx[n0], exp_word(w), model_idx);
    end
    model_idx = (model_idx + 1) % 64;
  endtask

  task automatic test_index_wrap();
    int n0;
    bit got;
    logic [DB-1:0] w;
    for (int k = 0; k < 65; k++) begin
      if (k == 0) model_idx = 0;
      n0 = dv_count;
      w = DB'($urandom);
      pulse_start(w, $urandom_range(12, 2), $urandom_range(30, 6), k == 0);
      wait_dv(n0, got);
      total++;
      if (!got || dv_data[n0] !== exp_word(w) || dv_idx[n0] !== 6'(model_idx)) begin
        bad++; $display("FAIL wrap_%0d data=%h idx=%0d exp=%h,%0d", k, dv_data[n0], dv_idx[n0], exp_word(w), model_idx);
      end
      model_idx = (model_idx + 1) % 64;
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_idx = 0;
    n0 = dv_count;
    w = DB'($urandom);
    pulse_start(w, $urandom_range(12, 2), $urandom_range(30, 6), 1'b0);
    wait_dv(n0, got);
    total++;
    if (!got || dv_data[n0] !== exp_word(w) || dv_idx[n0] !== 6'(model_idx)) begin
      bad++; $display("FAIL wrap_after_fs data=%h idx=%0d exp=%h,%0d", dv_data[n0], dv_idx[n0], exp_word(w), model_idx);
    end
    model_idx = (model_idx + 1) % 64;
  endtask

  task automatic test_reset_mid();
    int r0, n0;
    bit got;
    r0 = sclk_rises;
    pulse_start(DB'($urandom), $urandom_range(12, 2), $urandom_range(30, 6), 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (sclk_rises - r0 >= 10) break;
      tick();
    end
    n0 = dv_count;
    reset = 1'b0;
    #1;
    total++;
    if ({CNVST_N, CS_N, SCLK, data_valid, overrun, timeout_err} !== 6'b110000 || data !== '0 || sample_index !== '0) begin
      bad++; $display("FAIL reset_mid ctrl=%b data=%h idx=%0d exp=110000,0,0",
                      {CNVST_N, CS_N, SCLK, data_valid, overrun, timeout_err}, data, sample_index);
    end
    repeat (5) tick();
    reset = 1'b1;
    model_idx = 0;
    repeat (2) tick();
    total++;
    if (dv_count != n0) begin bad++; $display("FAIL reset_mid_partial got=%0d exp=0 pulses", dv_count - n0); end
    pulse_start(18'h3FFFF, 10, 20, 1'b0);
    wait_dv(n0, got);
    total++;
    if (!got || dv_data[n0] !== exp_word(18'h3FFFF) || dv_idx[n0] !== 6'd0) begin
      bad++; $display("FAIL reset_mid_next data=%h idx=%0d exp=%h,0", dv_data[n0], dv_idx[n0], exp_word(18'h3FFFF));
    end
    model_idx = 1;
  endtask

  task automatic test_twos_comp();
    int n0;
    bit got;
    logic [DB-1:0] want;
`ifdef ADC_READER_TWOS_COMP_EN
    want = 18'h00000;
`else
    want = 18'h20000;
`endif
    n0 = dv_count;
    pulse_start(18'h20000, 10, 20, 1'b0);
    wait_dv(n0, got);
    total++;
    if (!got || dv_data[n0] !== want || dv_idx[n0] !== 6'(model_idx)) begin
      bad++; $display("FAIL twos_comp data=%h idx=%0d exp=%h,%0d", dv_data[n0], dv_idx[n0], want, model_idx);
    end
    model_idx = (model_idx + 1) % 64;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overrun();
    test_frame_start_inflight();
    test_index_wrap();
    test_reset_mid();
    test_twos_comp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
